// File: rtl/uart_pattern_loader.sv
// UART-fed pattern buffer: received bytes are paired into 16-bit words in a 256x16 RAM,
// then replayed in a loop as a two-bit sample stream, MSB pair first.
module uart_pattern_loader #(
  parameter int CLK_FREQ = 48000000,
  parameter int SYM_RATE = 1200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fpga_rx,
  input  logic       play,
  input  logic       clr,
  output logic       sig,
  output logic       sig1,
  output logic       busy,
  output logic [8:0] word_cnt,
  output logic       full,
  output logic       frame_err
);

  localparam int SYM_CNT = CLK_FREQ / SYM_RATE;
  localparam int CNT_W   = (SYM_CNT > 1) ? $clog2(SYM_CNT) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(SYM_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(SYM_CNT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;

  rxState_t         r_state, w_next;
  logic [1:0]       r_sync;
  logic             r_rxPrev;
  logic             w_rx;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bitIdx;
  logic [7:0]       r_shift;
  logic             w_sampleHalf, w_sampleFull, w_byteOk, w_frameBad;

  logic             r_phase;
  logic [7:0]       r_lowByte;
  logic [8:0]       r_wordCnt;
  logic             w_clrEff, w_store, w_we;

  logic [15:0]      r_mem [0:255];
  logic [15:0]      r_ramQ;
  logic [7:0]       r_rdAddr;
  logic             r_prime;
  logic [2:0]       r_pair;
  logic [15:0]      r_word;
  logic             w_lastAddr;

  assign w_rx         = r_sync[1];
  assign w_sampleHalf = (r_cnt == HALF_M1);
  assign w_sampleFull = (r_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync   <= 2'b11;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync   <= {r_sync[0], fpga_rx};
      r_rxPrev <= w_rx;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_byteOk   = 1'b0;
    w_frameBad = 1'b0;
    case (r_state)
      RX_IDLE:  if (r_rxPrev && !w_rx) w_next = RX_START;
      RX_START: if (w_sampleHalf) w_next = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_sampleFull && (r_bitIdx == 3'd7)) w_next = RX_STOP;
      RX_STOP: begin
        if (w_sampleFull) begin
          w_next     = RX_IDLE;
          w_byteOk   = w_rx;
          w_frameBad = !w_rx;
        end
      end
      default:  w_next = RX_IDLE;
    endcase
  end

  // The bit timer restarts on every state change and on every data sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bitIdx  <= 3'd0;
      r_shift   <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      frame_err <= w_frameBad;
      if ((r_state == RX_IDLE) || (r_state != w_next) || w_sampleFull)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == RX_START)
        r_bitIdx <= 3'd0;
      else if ((r_state == RX_DATA) && w_sampleFull) begin
        r_bitIdx <= r_bitIdx + 3'd1;
        r_shift  <= {w_rx, r_shift[7:1]};
      end
    end
  end

  assign w_clrEff = clr && !busy;
  assign w_store  = w_byteOk && !play && !full;
  assign w_we     = w_store && r_phase && !w_clrEff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase   <= 1'b0;
      r_lowByte <= 8'd0;
      r_wordCnt <= 9'd0;
    end else if (w_clrEff) begin
      r_wordCnt <= 9'd0;
      r_phase   <= 1'b0;
    end else if (play || w_frameBad) begin
      r_phase <= 1'b0;
    end else if (w_store) begin
      if (!r_phase) begin
        r_lowByte <= r_shift;
        r_phase   <= 1'b1;
      end else begin
        r_wordCnt <= r_wordCnt + 9'd1;
        r_phase   <= 1'b0;
      end
    end
  end

  assign word_cnt = r_wordCnt;
  assign full     = r_wordCnt[8];

  // Plain synchronous-read array so the tools map it onto one SB_RAM40_4K.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wordCnt[7:0]] <= {r_shift, r_lowByte};
    r_ramQ <= r_mem[r_rdAddr];
  end

  assign w_lastAddr = (({1'b0, r_rdAddr} + 9'd1) == r_wordCnt);

  // Pair 0 comes straight from the RAM register; the address then advances so
  // the next word is ready by the time pair 7 has been shifted out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      r_prime  <= 1'b0;
      r_pair   <= 3'd0;
      r_rdAddr <= 8'd0;
      r_word   <= 16'd0;
      sig      <= 1'b0;
      sig1     <= 1'b0;
    end else if (!play) begin
      busy     <= 1'b0;
      r_prime  <= 1'b0;
      r_pair   <= 3'd0;
      r_rdAddr <= 8'd0;
      sig      <= 1'b0;
      sig1     <= 1'b0;
    end else if (!busy) begin
      if (r_wordCnt != 9'd0) begin
        busy    <= 1'b1;
        r_prime <= 1'b1;
      end
    end else if (r_prime) begin
      r_prime <= 1'b0;
    end else begin
      r_pair <= r_pair + 3'd1;
      if (r_pair == 3'd0) begin
        {sig, sig1} <= r_ramQ[15:14];
        r_word      <= {r_ramQ[13:0], 2'b00};
        r_rdAddr    <= w_lastAddr ? 8'd0 : r_rdAddr + 8'd1;
      end else begin
        {sig, sig1} <= r_word[15:14];
        r_word      <= {r_word[13:0], 2'b00};
      end
    end
  end

endmodule
